// File: rtl/bit_serializer_pkg.sv
// Shared definitions for serial-stream stages: FSM state encodings and
// default word width / idle line level.
package bit_serializer_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  localparam int DEFAULT_WIDTH    = 8;
  localparam bit DEFAULT_IDLE_BIT = 1'b0;

endpackage : bit_serializer_pkg

// File: rtl/bit_serializer.sv
// Parallel-in/serial-out stage: accepts a WIDTH-bit word over valid/ready and
// emits it one bit per clock, with gapless reload on the last bit of a frame.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = DEFAULT_IDLE_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  ser_state_t       state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             sout_reg, sout_next;
  logic             sout_valid_reg, sout_valid_next;
  logic             frame_done_reg, frame_done_next;
  logic             load;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Ready in idle or on the last bit of a frame, which is what makes reload gapless.
  assign din_ready = reset && ((state_reg == SER_IDLE) || (cnt_reg == '0));
  assign load      = din_valid && din_ready;

  always_comb begin
    state_next      = state_reg;
    shreg_next      = shreg_reg;
    cnt_next        = cnt_reg;
    sout_next       = IDLE_BIT;
    sout_valid_next = 1'b0;
    frame_done_next = 1'b0;

    if (state_reg == SER_SHIFT && cnt_reg != '0) begin
      // The head bit goes straight to the output register; shreg keeps the rest.
      sout_next       = head_bit(shreg_reg);
      shreg_next      = advance(shreg_reg);
      cnt_next        = cnt_reg - CW'(1);
      sout_valid_next = 1'b1;
      frame_done_next = (cnt_reg == CW'(1));
    end else if (load) begin
      state_next      = SER_SHIFT;
      sout_next       = head_bit(din);
      shreg_next      = advance(din);
      cnt_next        = CNT_LAST;
      sout_valid_next = 1'b1;
    end else begin
      state_next = SER_IDLE;
      shreg_next = '0;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= SER_IDLE;
      shreg_reg      <= '0;
      cnt_reg        <= '0;
      sout_reg       <= IDLE_BIT;
      sout_valid_reg <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shreg_reg      <= shreg_next;
      cnt_reg        <= cnt_next;
      sout_reg       <= sout_next;
      sout_valid_reg <= sout_valid_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign sout       = sout_reg;
  assign sout_valid = sout_valid_reg;
  assign frame_done = frame_done_reg;

endmodule : bit_serializer

// File: tb/tb_bit_serializer.sv
// Randomized scoreboard bench for bit_serializer: MSB-first and LSB-first
// instances share stimulus; expected bits are queued per accepted word.
module tb_bit_serializer;

  localparam int W = 8;
  localparam bit IDLE = 1'b0;

  typedef struct {
    bit b;
    bit last;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         rdy_m, sout_m, sv_m, fd_m;
  logic         rdy_l, sout_l, sv_l, fd_l;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;
  exp_t qm[$];
  exp_t ql[$];

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE)) dut_m (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(rdy_m), .sout(sout_m), .sout_valid(sv_m), .frame_done(fd_m)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE)) dut_l (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(rdy_l), .sout(sout_l), .sout_valid(sv_l), .frame_done(fd_l)
  );

  function automatic void chk(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%b required=%b", nm, $time, act, exp);
    end
  endfunction

  // Reference model: a word is accepted when nothing beyond the visible bit is pending.
  always @(posedge clk) begin
    logic [W-1:0] w;
    started <= 1'b1;
    if (!reset) begin
      qm.delete();
      ql.delete();
    end else if (din_valid && qm.size() == 0) begin
      w = din;
      $display("accept word=%h t=%0t", w, $time);
      for (int i = 0; i < W; i++) begin
        qm.push_back('{b: w[W-1-i], last: (i == W-1)});
        ql.push_back('{b: w[i],     last: (i == W-1)});
      end
    end
  end

  // Monitor: compares what each DUT presents against the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      chk("ready_m", rdy_m, reset && (qm.size() <= 1));
      chk("ready_l", rdy_l, reset && (ql.size() <= 1));
      if (qm.size() > 0) begin
        e = qm.pop_front();
        chk("valid_m", sv_m, 1'b1);
        chk("sout_m", sout_m, e.b);
        chk("done_m", fd_m, e.last);
      end else begin
        chk("valid_m", sv_m, 1'b0);
        chk("idle_m", sout_m, IDLE);
        chk("done_m", fd_m, 1'b0);
      end
      if (ql.size() > 0) begin
        e = ql.pop_front();
        chk("valid_l", sv_l, 1'b1);
        chk("sout_l", sout_l, e.b);
        chk("done_l", fd_l, e.last);
      end else begin
        chk("valid_l", sv_l, 1'b0);
        chk("idle_l", sout_l, IDLE);
        chk("done_l", fd_l, 1'b0);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds din_valid until the word is taken; leaves din_valid high so the caller
  // can chain the next word gaplessly.
  task automatic send_word(input logic [W-1:0] w);
    logic r;
    int   n = 0;
    din       = w;
    din_valid = 1'b1;
    do begin
      @(negedge clk);
      r = rdy_m;
      @(posedge clk);
      n++;
    end while (!r && n < 100);
    #1;
    if (!r) begin
      failures++;
      $display("FAIL send_timeout word=%h actual=not_ready required=ready", w);
    end
  endtask

  initial begin
    cycles(2);
    reset = 1'b1;

    // Single word, then noise on din/din_valid while the frame is busy.
    send_word(8'b10110100);
    for (int i = 0; i < 6; i++) begin
      din       = W'($urandom);
      din_valid = (i % 2 == 0);
      cycles(1);
    end
    din_valid = 1'b0;
    cycles(6);

    // Back-to-back frames with valid held high.
    send_word(8'hFF);
    send_word(8'h00);
    din_valid = 1'b0;
    cycles(12);

    // Reset partway through a frame, then a fresh word.
    send_word(8'hA5);
    din_valid = 1'b0;
    cycles(2);
    reset     = 1'b0;
    din_valid = 1'b1;
    cycles(1);
    din_valid = 1'b0;
    reset     = 1'b1;
    cycles(1);
    send_word(8'h3C);
    din_valid = 1'b0;
    cycles(10);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      din       = W'($urandom);
      din_valid = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 99) != 0);
      cycles(1);
    end
    reset     = 1'b1;
    din_valid = 1'b0;
    cycles(12);

    checks++;
    if (qm.size() != 0 || ql.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d/%0d required=0", qm.size(), ql.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bit_serializer

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the Moore sequence detector.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clk on sout, which drives the detector's serial inp.
- Supports gapless back-to-back words, so the detector sees continuous streams, including patterns that straddle word boundaries.

Parameters:
- WIDTH, 8, word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 = din[WIDTH-1] sent first; 0 = din[0] sent first.
- IDLE_BIT, 0, value driven on sout when no frame is active.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (sampled on rising clk edge; 0 = reset).
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a valid word.
- din_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial bit; feeds the detector's inp.
- sout_valid  output  1  sout carries a frame bit this cycle.
- frame_done  output  1  one-cycle pulse, high together with the last bit of a frame.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE, shift register=0, bit counter=0.
  - sout=IDLE_BIT, sout_valid=0, frame_done=0.
  - din_ready is forced to 0 combinationally while reset==0.
- States: IDLE, SHIFT.
- Output timing:
  - sout, sout_valid and frame_done are registered.
  - din_ready is combinational from state and counter.
- IDLE:
  - din_ready=1, sout=IDLE_BIT, sout_valid=0.
  - On din_valid&&din_ready at edge k: capture din, set counter=WIDTH-1, go to SHIFT.
  - The first bit appears on sout in the cycle after edge k (1-cycle latency).
- SHIFT:
  - sout_valid=1 and sout=current head bit (MSB or LSB per MSB_FIRST).
  - Each edge: advance the shift register by one, decrement the counter.
  - A frame occupies exactly WIDTH consecutive sout_valid cycles.
- Last-bit cycle (counter==0):
  - frame_done=1 and din_ready=1.
  - If din_valid: load the new word, reset counter=WIDTH-1, stay in SHIFT. The new word's first bit follows in the next cycle with no gap.
  - Else: go to IDLE, so sout returns to IDLE_BIT and sout_valid=0 next cycle.
- Other SHIFT cycles: din_ready=0, din_valid is ignored, no data is captured.
- Counter width is $clog2(WIDTH). The counter never wraps below 0; reaching 0 forces reload or IDLE.
- din is sampled only on an accepted handshake; din changes at any other time have no effect.
- Reset mid-frame aborts the frame: remaining bits are discarded, frame_done is not pulsed, and outputs take reset values at the next edge.
- Simultaneous reset==0 and din_valid: reset wins and the word is not accepted.
- din_valid held high continuously produces a continuous bitstream with sout_valid constantly 1.

Decomposition:
- Shared header (include file) holds:
  - state encodings SER_IDLE=1'b0 and SER_SHIFT=1'b1;
  - the default WIDTH;
  - the IDLE_BIT default.
- The detector and any future serial-stream stages reuse the same header.
- No sub-module is needed. The shift register, counter and two-state FSM stay in one module.
- The detector's bench instantiates bit_serializer to generate inp.

Test Plan:
- Single word, MSB_FIRST=1, din=8'b10110100 accepted at edge 2:
  - sout = 1,0,1,1,0,1,0,0 on cycles 3..10 with sout_valid=1;
  - frame_done=1 only on cycle 10;
  - din_ready=0 on cycles 3..9;
  - IDLE_BIT with sout_valid=0 from cycle 11.
- LSB-first (MSB_FIRST=0), din=8'hB4 -> sout = 0,0,1,0,1,1,0,1.
- Back-to-back:
  - din_valid held high with 8'hFF then 8'h00 -> 16 consecutive sout_valid cycles (eight 1s then eight 0s), no idle gap;
  - frame_done pulses on cycles 8 and 16.
- Ignore while busy:
  - din changes and din_valid pulses during cycles 3..9 of a frame -> output bits unchanged;
  - no extra frame emitted.
- Reset mid-frame:
  - reset=0 asserted after the 3rd bit of 8'hA5 -> next edge gives sout=IDLE_BIT, sout_valid=0, no frame_done;
  - after reset release, a new word 8'h3C serializes correctly from its first bit.
- Integration:
  - sout drives the sequence detector's inp, with the same clk and reset;
  - words 8'b01101101 then 8'b10100000 sent gaplessly;
  - det matches the golden-model pattern count, including a detection spanning the word boundary.
